// File: rtl/ht_task_dispatcher_pkg.sv
// Shared hash-table definitions: dispatcher FSM states and engine opcodes.
// The opcode value doubles as the index of the engine that serves it.
package hash_table;

    typedef enum logic [1:0] {
        DSP_IDLE,
        DSP_RUN,
        DSP_DRAIN
    } ht_dispatch_state_t;

    localparam int OP_INIT   = 0;
    localparam int OP_SEARCH = 1;
    localparam int OP_INSERT = 2;
    localparam int OP_DELETE = 3;

endpackage

// File: rtl/ht_task_dispatcher_if.sv
// Task stream and engine bank signals seen by the dispatcher.
// master drives tasks and engine feedback; slave is the dispatcher itself.
interface ht_task_dispatcher_if #(
    parameter int DATA_WIDTH   = 64,
    parameter int OP_WIDTH     = 2,
    parameter int ENG_CNT      = 4,
    parameter int MAX_INFLIGHT = 8
);
    localparam int CNT_WIDTH = $clog2(MAX_INFLIGHT + 1);
    localparam int EW        = $clog2(ENG_CNT);

    logic [DATA_WIDTH-1:0] task_i;
    logic [OP_WIDTH-1:0]   task_op_i;
    logic                  task_valid_i;
    logic                  task_ready_o;
    logic [DATA_WIDTH-1:0] eng_task_o;
    logic [ENG_CNT-1:0]    eng_valid_o;
    logic [ENG_CNT-1:0]    eng_ready_i;
    logic [ENG_CNT-1:0]    eng_done_i;
    logic [EW-1:0]         owner_o;
    logic [CNT_WIDTH-1:0]  inflight_o;
    logic                  busy_o;
    logic                  bad_op_o;
    logic                  proto_err_o;

    modport master (
        output task_i, task_op_i, task_valid_i, eng_ready_i, eng_done_i,
        input  task_ready_o, eng_task_o, eng_valid_o, owner_o, inflight_o,
               busy_o, bad_op_o, proto_err_o
    );

    modport slave (
        input  task_i, task_op_i, task_valid_i, eng_ready_i, eng_done_i,
        output task_ready_o, eng_task_o, eng_valid_o, owner_o, inflight_o,
               busy_o, bad_op_o, proto_err_o
    );

endinterface

// File: rtl/ht_dispatch_credit.sv
// In-flight task accounting for the owning engine, credit check and
// detection of done pulses that do not belong to an outstanding task.
module ht_dispatch_credit
    import hash_table::*;
#(
    parameter  int MAX_INFLIGHT = 8,
    parameter  int ENG_CNT      = 4,
    localparam int CNT_WIDTH    = $clog2(MAX_INFLIGHT + 1),
    localparam int EW           = $clog2(ENG_CNT)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [EW-1:0]        owner,
    input  logic                 accept,
    input  logic [ENG_CNT-1:0]   done,
    output logic [CNT_WIDTH-1:0] inflight,
    output logic [CNT_WIDTH-1:0] inflight_next,
    output logic                 credit_ok,
    output logic                 proto_err
);

    logic [ENG_CNT-1:0] owner_mask;
    logic               owner_done;
    logic               retire;
    logic               spurious;

    assign owner_mask = ENG_CNT'(1) << owner;
    assign owner_done = |(done & owner_mask);
    assign retire     = owner_done && (inflight != '0);
    assign spurious   = (|(done & ~owner_mask)) || (owner_done && (inflight == '0));

    // Credit uses the registered count, so a same-cycle done never frees a slot early
    assign credit_ok     = inflight < CNT_WIDTH'(MAX_INFLIGHT);
    assign inflight_next = inflight + CNT_WIDTH'(accept) - CNT_WIDTH'(retire);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight  <= '0;
            proto_err <= 1'b0;
        end else begin
            inflight  <= inflight_next;
            proto_err <= spurious;
        end
    end

endmodule

// File: rtl/ht_task_dispatcher.sv
// Routes an in-order task stream to the engine selected by its opcode through
// a single registered slot, switching owner only once all its tasks complete.
module ht_task_dispatcher
    import hash_table::*;
#(
    parameter  int DATA_WIDTH   = 64,
    parameter  int OP_WIDTH     = 2,
    parameter  int ENG_CNT      = 4,
    parameter  int MAX_INFLIGHT = 8,
    localparam int CNT_WIDTH    = $clog2(MAX_INFLIGHT + 1),
    localparam int EW           = $clog2(ENG_CNT)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ht_task_dispatcher_if.slave bus
);

    ht_dispatch_state_t    state, state_next;
    logic                  slot_full;
    logic [EW-1:0]         owner;
    logic [DATA_WIDTH-1:0] eng_task;
    logic                  bad_op;
    logic [ENG_CNT-1:0]    owner_mask;
    logic                  head_is_owner, head_foreign, op_in_range;
    logic                  slot_fire, slot_free, task_ready;
    logic                  take, take_good, take_bad;
    logic [CNT_WIDTH-1:0]  inflight, inflight_next;
    logic                  credit_ok, proto_err;

    assign owner_mask    = ENG_CNT'(1) << owner;
    assign head_is_owner = bus.task_op_i == OP_WIDTH'(owner);
    assign head_foreign  = bus.task_valid_i && !head_is_owner;
    assign op_in_range   = 32'(bus.task_op_i) < 32'(ENG_CNT);

    assign slot_fire  = slot_full && (|(bus.eng_ready_i & owner_mask));
    assign slot_free  = !slot_full || slot_fire;
    // Only an idle dispatcher may take a foreign opcode; that is the zero-bubble switch
    assign task_ready = slot_free && credit_ok && (head_is_owner || (state == DSP_IDLE));
    assign take       = bus.task_valid_i && task_ready;
    assign take_good  = take && op_in_range;
    assign take_bad   = take && !op_in_range;

    ht_dispatch_credit #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .ENG_CNT      (ENG_CNT)
    ) u_credit (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .owner         (owner),
        .accept        (take_good),
        .done          (bus.eng_done_i),
        .inflight      (inflight),
        .inflight_next (inflight_next),
        .credit_ok     (credit_ok),
        .proto_err     (proto_err)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            DSP_IDLE: begin
                if (take_good) state_next = DSP_RUN;
            end
            DSP_RUN: begin
                if (inflight_next == '0) state_next = DSP_IDLE;
                else if (head_foreign)   state_next = DSP_DRAIN;
            end
            DSP_DRAIN: begin
                if (inflight_next == '0) state_next = DSP_IDLE;
                else if (!head_foreign)  state_next = DSP_RUN;
            end
            default: state_next = DSP_IDLE;
        endcase
    end

    // Bad opcodes are consumed without touching slot, owner or count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= DSP_IDLE;
            slot_full <= 1'b0;
            owner     <= '0;
            eng_task  <= '0;
            bad_op    <= 1'b0;
        end else begin
            state  <= state_next;
            bad_op <= take_bad;
            if (take_good) begin
                slot_full <= 1'b1;
                eng_task  <= bus.task_i;
                owner     <= bus.task_op_i[EW-1:0];
            end else if (slot_fire) begin
                slot_full <= 1'b0;
            end
        end
    end

    assign bus.task_ready_o = task_ready;
    assign bus.eng_task_o   = eng_task;
    assign bus.eng_valid_o  = slot_full ? owner_mask : '0;
    assign bus.owner_o      = owner;
    assign bus.inflight_o   = inflight;
    assign bus.busy_o       = inflight != '0;
    assign bus.bad_op_o     = bad_op;
    assign bus.proto_err_o  = proto_err;

endmodule
